// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and helpers shared by the multi-cycle ALU
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_RSVD  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply/divide occupy the 11xx corner; bit 0 selects signed, bit 1 selects divide.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier / restoring divider on magnitudes
module alu_muldiv_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  dbz,
  output logic                  ovf
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W);
  localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     mc_q, mc_d;
  logic [W-1:0]     a_q, a_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       mul_sum, div_shift, div_diff;
  logic [2*W-1:0]   prod;

  always_comb begin
    a_neg     = signed_op & a[W-1];
    b_neg     = signed_op & b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    mul_sum   = {1'b0, hi_q} + ({(W+1){lo_q[0]}} & {1'b0, mc_q});
    div_shift = {hi_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, mc_q};
  end

  // hi_q:lo_q is the shared accumulator: product for multiply, remainder:quotient for divide.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mc_d     = mc_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = is_div ? a_mag : b_mag;
      mc_d     = is_div ? b_mag : a_mag;
      a_d      = a;
      is_div_d = is_div;
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = is_div & a_neg;
      dbz_d    = is_div & (b == '0);
      ovf_d    = is_div & signed_op & (a == MIN_VAL) & (b == '1);
    end else if (run_q) begin
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          if (!div_diff[W]) begin
            hi_d = div_diff[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b1};
          end else begin
            hi_d = div_shift[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[W:1];
          lo_d = {mul_sum[0], lo_q[W-1:1]};
        end
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mc_q     <= mc_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sign correction is applied combinationally during the final cycle and captured by the owner.
  always_comb begin
    prod = {hi_q, lo_q};
    if (neg_lo_q) prod = -prod;
    hi = prod[2*W-1:W];
    lo = prod[W-1:0];
    if (is_div_q) begin
      if (dbz_q) begin
        lo = '1;
        hi = a_q;
      end else begin
        lo = neg_lo_q ? -lo_q : lo_q;
        hi = neg_hi_q ? -hi_q : hi_q;
      end
    end
  end

  assign done = run_q && (cnt_q == CNT_LAST);
  assign dbz  = dbz_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle EX-stage ALU with valid/ready handshake and registered results
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  div_by_zero
);

  localparam int W = DATA_WIDTH;

  state_e       state_q, state_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic         ovf_q, ovf_d;
  logic         cout_q, cout_d;
  logic         zero_q, zero_d;
  logic         dbz_q, dbz_d;

  logic [W:0]         sc_sum, sc_diff;
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       sc_lo;
  logic               sc_ovf, sc_cout;
  logic               accept;

  logic               md_start, md_done, md_dbz, md_ovf;
  logic [W-1:0]       md_hi, md_lo;

  alu_muldiv_iter #(
    .DATA_WIDTH(W)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .signed_op(ALUop[0]),
    .is_div   (ALUop[1]),
    .a        (A),
    .b        (B),
    .done     (md_done),
    .hi       (md_hi),
    .lo       (md_lo),
    .dbz      (md_dbz),
    .ovf      (md_ovf)
  );

  always_comb begin
    sc_sum  = {1'b0, A} + {1'b0, B};
    sc_diff = {1'b0, A} - {1'b0, B};
    shamt   = A[SHAMT_W-1:0];
    sc_lo   = '0;
    sc_ovf  = 1'b0;
    sc_cout = 1'b0;
    case (ALUop)
      OP_AND:  sc_lo = A & B;
      OP_OR:   sc_lo = A | B;
      OP_ADD: begin
        sc_lo   = sc_sum[W-1:0];
        sc_cout = sc_sum[W];
        sc_ovf  = (A[W-1] == B[W-1]) && (sc_sum[W-1] != A[W-1]);
      end
      OP_NOR:  sc_lo = ~(A | B);
      OP_SLL:  sc_lo = B << shamt;
      OP_XOR:  sc_lo = A ^ B;
      OP_SUB: begin
        sc_lo   = sc_diff[W-1:0];
        sc_cout = sc_diff[W];
        sc_ovf  = (A[W-1] != B[W-1]) && (sc_diff[W-1] != A[W-1]);
      end
      OP_SLT:  sc_lo = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_lo = {{(W-1){1'b0}}, sc_diff[W]};
      OP_SRL:  sc_lo = B >> shamt;
      OP_SRA:  sc_lo = $unsigned($signed(B) >>> shamt);
      default: sc_lo = '0;
    endcase
  end

  // DONE with out_ready behaves like IDLE so back-to-back single-cycle ops issue every cycle.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    md_start = 1'b0;
    in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept   = in_valid && in_ready;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
        if (accept) begin
          if (is_muldiv(ALUop)) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            lo_d    = sc_lo;
            hi_d    = '0;
            ovf_d   = sc_ovf;
            cout_d  = sc_cout;
            zero_d  = (sc_lo == '0);
            dbz_d   = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          lo_d    = md_lo;
          hi_d    = md_hi;
          ovf_d   = md_ovf;
          cout_d  = 1'b0;
          zero_d  = (md_lo == '0);
          dbz_d   = md_dbz;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign out_valid   = (state_q == ST_DONE);
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign Overflow    = ovf_q;
  assign CarryOut    = cout_q;
  assign Zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc with directed vectors
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [W-1:0] a, b;
  logic [3:0]   alu_op;
  logic         in_ready, out_valid, overflow, carry_out, zero, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    logic         cout;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    logic         cout;
    logic         dbz;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a),
    .B          (b),
    .ALUop      (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .Overflow   (overflow),
    .CarryOut   (carry_out),
    .Zero       (zero),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic expect_res(input string nm, input vec_t v);
    exp_t e;
    e.lo   = v.lo;
    e.hi   = v.hi;
    e.ovf  = v.ovf;
    e.cout = v.cout;
    e.dbz  = v.dbz;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Called just after a rising edge; returns just after the edge on which the op is accepted.
  task automatic send(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int n = 0;
    alu_op   = op;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_op   = 4'($urandom_range(0, 15));
  endtask

  // Counts negedges with in_ready low after a mul/div accept; offers a junk op meanwhile.
  task automatic wait_busy(input string nm);
    int n = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({nm, "_busy_cycles"}, W'(n), W'(W + 1));
    check({nm, "_valid_after_busy"}, W'(out_valid), W'(1));
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got lo=%h hi=%h, required no result", result_lo, result_hi);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_lo"}, result_lo, e.lo);
        check({nm, "_hi"}, result_hi, e.hi);
        check({nm, "_ovf"}, W'(overflow), W'(e.ovf));
        check({nm, "_cout"}, W'(carry_out), W'(e.cout));
        check({nm, "_zero"}, W'(zero), W'(e.lo == '0));
        check({nm, "_dbz"}, W'(div_by_zero), W'(e.dbz));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t sc_vecs[12];
    vec_t md_vecs[7];
    vec_t v;
    int   n;
    logic seen_valid;

    sc_vecs[0]  = '{4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, '0, 1'b0, 1'b1, 1'b0};
    sc_vecs[1]  = '{4'b0111, 32'hFFFFFFFD, 32'd2,        32'd1,        '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[2]  = '{4'b1000, 32'hFFFFFFFD, 32'd2,        32'd0,        '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[3]  = '{4'b1010, 32'd4,        32'h80000000, 32'hF8000000, '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[4]  = '{4'b1001, 32'd4,        32'h80000000, 32'h08000000, '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[5]  = '{4'b0100, 32'h24,       32'd1,        32'h10,       '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[6]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        '0, 1'b0, 1'b1, 1'b0};
    sc_vecs[7]  = '{4'b0110, 32'd3,        32'd3,        32'd0,        '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[8]  = '{4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, '0, 1'b1, 1'b0, 1'b0};
    sc_vecs[9]  = '{4'b0011, 32'd0,        32'd0,        32'hFFFFFFFF, '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[10] = '{4'b0001, 32'hF0,       32'h0F,       32'hFF,       '0, 1'b0, 1'b0, 1'b0};
    sc_vecs[11] = '{4'b1011, 32'd5,        32'd5,        32'd0,        '0, 1'b0, 1'b0, 1'b0};

    md_vecs[0] = '{4'b1101, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    md_vecs[1] = '{4'b1100, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 32'h00000002, 1'b0, 1'b0, 1'b0};
    md_vecs[2] = '{4'b1111, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    md_vecs[3] = '{4'b1110, 32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        1'b0, 1'b0, 1'b1};
    md_vecs[4] = '{4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0, 1'b0};
    md_vecs[5] = '{4'b1110, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0};
    md_vecs[6] = '{4'b1101, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    alu_op    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_lo", result_lo, '0);
    check("reset_hi", result_hi, '0);
    check("reset_flags", W'({overflow, carry_out, zero, div_by_zero}), W'(0));
    @(posedge clk);
    #1;

    v = '{4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, '0, 1'b1, 1'b0, 1'b0};
    expect_res("add_ovf", v);
    send(v.op, v.a, v.b);
    @(negedge clk);
    check("add_latency_valid", W'(out_valid), W'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      expect_res($sformatf("sc%0d_op%b", i, sc_vecs[i].op), sc_vecs[i]);
      send(sc_vecs[i].op, sc_vecs[i].a, sc_vecs[i].b);
    end
    @(negedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      expect_res($sformatf("md%0d_op%b", i, md_vecs[i].op), md_vecs[i]);
      send(md_vecs[i].op, md_vecs[i].a, md_vecs[i].b);
      wait_busy($sformatf("md%0d", i));
      @(posedge clk);
      #1;
    end

    out_ready = 1'b0;
    v = '{4'b0010, 32'd3, 32'd4, 32'd7, '0, 1'b0, 1'b0, 1'b0};
    expect_res("bp_add", v);
    send(v.op, v.a, v.b);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", i), W'(out_valid), W'(1));
      check($sformatf("bp%0d_in_ready", i), W'(in_ready), W'(0));
      check($sformatf("bp%0d_lo", i), result_lo, 32'd7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    v = '{4'b0101, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, '0, 1'b0, 1'b0, 1'b0};
    expect_res("bp_xor", v);
    send(v.op, v.a, v.b);
    @(negedge clk);
    check("bp_xor_valid_next", W'(out_valid), W'(1));
    @(posedge clk);
    #1;

    send(4'b1110, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_in_ready", W'(in_ready), W'(1));
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_stale", W'(seen_valid), W'(0));
    @(posedge clk);
    #1;
    v = '{4'b0000, 32'hF0, 32'h3C, 32'h30, '0, 1'b0, 1'b0, 1'b0};
    expect_res("post_abort_and", v);
    send(v.op, v.a, v.b);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
